ahb_sram_ctrl: RTL and testbench

- Parametrised AHB-Lite slave wrapping an inferred single-port synchronous SRAM array.
- Successor to the fixed 4-state SRAM bridge. Adds:
  - configurable data width, depth and wait states
  - byte/halfword/word writes with byte-lane enables
  - read-after-write forwarding
  - two-cycle ERROR responses
- Single clock domain (hclk_i). Sits on the system AHB matrix as data/program RAM for the core and vector unit.

---
 rtl/ahb_sram_ctrl_if.sv | 29 ++
 rtl/ahb_sram_ctrl.sv | 155 +++++++++++++++
 tb/tb_ahb_sram_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_sram_ctrl_if.sv
// AHB-Lite slave-side bus bundle for ahb_sram_ctrl.
// Master drives address/control/write data; slave returns data/ready/resp.
interface ahb_sram_ctrl_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  hsel_i;
   logic [ADDR_WIDTH-1:0] haddr_i;
   logic [1:0]            htrans_i;
   logic                  hwrite_i;
   logic [2:0]            hsize_i;
   logic [DATA_WIDTH-1:0] hwdata_i;
   logic                  hready_i;
   logic [DATA_WIDTH-1:0] hrdata_o;
   logic                  hreadyout_o;
   logic                  hresp_o;

   modport master (
      output hsel_i, haddr_i, htrans_i, hwrite_i,
      output hsize_i, hwdata_i, hready_i,
      input  hrdata_o, hreadyout_o, hresp_o
   );

   modport slave (
      input  hsel_i, haddr_i, htrans_i, hwrite_i,
      input  hsize_i, hwdata_i, hready_i,
      output hrdata_o, hreadyout_o, hresp_o
   );
endinterface

// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite slave around an inferred single-port SRAM with wait states,
// byte lanes, read-after-write forwarding and two-cycle ERROR responses.
module ahb_sram_ctrl #(
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH_WORDS = 4096,
   parameter int WAIT_STATES = 1,
   parameter int ADDR_WIDTH  = 32
) (
   input logic             hclk_i,
   input logic             hresetn_i,
   ahb_sram_ctrl_if.slave  bus
);
   localparam int NB   = DATA_WIDTH / 8;
   localparam int OFFW = $clog2(NB);
   localparam int IDXW = $clog2(DEPTH_WORDS);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT, S_DONE, S_ERR1, S_ERR2
   } state_t;

   state_t                r_state;
   logic [1:0]            r_cnt;
   logic                  r_write;
   logic [IDXW-1:0]       r_idx;
   logic [2:0]            r_size;
   logic [OFFW-1:0]       r_off;
   logic                  r_rdy;
   logic                  r_resp;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [DATA_WIDTH-1:0] r_buf;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

   logic                  w_free;
   logic                  w_acc;
   logic                  w_err;
   logic                  w_oob;
   logic                  w_misal;
   logic                  w_bigsz;
   logic [OFFW-1:0]       w_amask;
   logic [OFFW-1:0]       w_off;
   logic [IDXW-1:0]       w_idx;
   logic [NB-1:0]         w_be;
   logic                  w_commit;
   logic                  w_fwd;
   logic [DATA_WIDTH-1:0] w_rd_word;

   assign bus.hreadyout_o = r_rdy;
   assign bus.hresp_o     = r_resp;
   assign bus.hrdata_o    = r_rdata;

   assign w_free = (r_state == S_IDLE) || (r_state == S_DONE) ||
                   (r_state == S_ERR2);
   assign w_acc  = bus.hsel_i & bus.htrans_i[1] & bus.hready_i & w_free;
   assign w_off  = bus.haddr_i[OFFW-1:0];
   assign w_idx  = bus.haddr_i[OFFW +: IDXW];

   always_comb begin
      w_amask = '0;
      for (int i = 0; i < OFFW; i++)
         w_amask[i] = int'(bus.hsize_i) > i;
   end

   assign w_oob   = (bus.haddr_i >> (OFFW + IDXW)) != '0;
   assign w_misal = (w_off & w_amask) != '0;
   assign w_bigsz = int'(bus.hsize_i) > OFFW;
   assign w_err   = w_oob | w_misal | w_bigsz;

   // little-endian lane mask from the latched size and offset
   always_comb begin
      w_be = '0;
      for (int i = 0; i < NB; i++)
         w_be[i] = (i >= int'(r_off)) &&
                   (i < int'(r_off) + (1 << r_size));
   end

   assign w_commit = (r_state == S_DONE) & r_write;
   assign w_fwd    = w_commit & (w_idx == r_idx);

   always_comb begin
      w_rd_word = r_mem[w_idx];
      for (int i = 0; i < NB; i++)
         if (w_fwd && w_be[i])
            w_rd_word[8*i +: 8] = bus.hwdata_i[8*i +: 8];
   end

   always_ff @(posedge hclk_i) begin
      if (w_commit)
         for (int i = 0; i < NB; i++)
            if (w_be[i])
               r_mem[r_idx][8*i +: 8] <= bus.hwdata_i[8*i +: 8];
      if (w_acc && !w_err && !bus.hwrite_i)
         r_buf <= w_rd_word;
   end

   always_ff @(posedge hclk_i or negedge hresetn_i) begin
      if (!hresetn_i) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_write <= 1'b0;
         r_idx   <= '0;
         r_size  <= '0;
         r_off   <= '0;
         r_rdy   <= 1'b1;
         r_resp  <= 1'b0;
         r_rdata <= '0;
      end else if (w_acc) begin
         r_write <= bus.hwrite_i;
         r_idx   <= w_idx;
         r_size  <= bus.hsize_i;
         r_off   <= w_off;
         if (w_err) begin
            r_state <= S_ERR1;
            r_rdy   <= 1'b0;
            r_resp  <= 1'b1;
         end else if (WAIT_STATES > 0) begin
            r_state <= S_WAIT;
            r_cnt   <= 2'(WAIT_STATES - 1);
            r_rdy   <= 1'b0;
            r_resp  <= 1'b0;
         end else begin
            r_state <= S_DONE;
            r_rdy   <= 1'b1;
            r_resp  <= 1'b0;
            if (!bus.hwrite_i)
               r_rdata <= w_rd_word;
         end
      end else begin
         unique case (r_state)
            S_WAIT: begin
               if (r_cnt == '0) begin
                  r_state <= S_DONE;
                  r_rdy   <= 1'b1;
                  if (!r_write)
                     r_rdata <= r_buf;
               end else begin
                  r_cnt <= r_cnt - 2'd1;
               end
            end
            S_ERR1: begin
               r_state <= S_ERR2;
               r_rdy   <= 1'b1;
               r_resp  <= 1'b1;
            end
            S_DONE, S_ERR2: begin
               r_state <= S_IDLE;
               r_rdy   <= 1'b1;
               r_resp  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Bench for ahb_sram_ctrl: pipelined AHB master, byte-level reference
// memory, and an independent monitor popping a scoreboard queue.
module tb_ahb_sram_ctrl;
   localparam int DW    = 32;
   localparam int AW    = 32;
   localparam int DEPTH = 64;
   localparam int WS    = 1;
   localparam int NB    = 4;

   typedef struct {
      bit        sel;
      bit [1:0]  trans;
      bit        wr;
      bit [31:0] addr;
      bit [2:0]  size;
      bit [31:0] wdata;
      bit        hold;
   } item_t;

   typedef struct {
      bit        err;
      bit        rd;
      bit [31:0] data;
   } exp_t;

   logic hclk    = 1'b0;
   logic hresetn = 1'b0;
   logic hold    = 1'b0;
   bit   mon_en  = 1'b0;

   item_t     items[$];
   exp_t      exp_q[$];
   bit [7:0]  ref_mem [DEPTH*NB];
   int        n_cmp  = 0;
   int        n_fail = 0;

   always #5 hclk = ~hclk;

   ahb_sram_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   assign bus.hready_i = bus.hreadyout_o & ~hold;

   ahb_sram_ctrl #(
      .DATA_WIDTH(DW), .DEPTH_WORDS(DEPTH),
      .WAIT_STATES(WS), .ADDR_WIDTH(AW)
   ) dut (
      .hclk_i(hclk), .hresetn_i(hresetn), .bus(bus)
   );

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic item_t mk(bit sel, bit [1:0] tr, bit wr,
                                bit [31:0] a, bit [2:0] sz,
                                bit [31:0] d, bit h);
      item_t it;
      it.sel = sel; it.trans = tr; it.wr = wr; it.addr = a;
      it.size = sz; it.wdata = d; it.hold = h;
      return it;
   endfunction

   // Reference behaviour: transfers take effect in bus order.
   task automatic model_issue(item_t it);
      exp_t      e;
      int        nbytes;
      bit [31:0] base;
      nbytes = 1 << it.size;
      e.err  = (it.addr >= DEPTH*NB) || (it.size > 2) ||
               (it.addr % nbytes != 0);
      e.rd   = !it.wr;
      e.data = '0;
      base   = it.addr - (it.addr % NB);
      if (!e.err && it.wr)
         for (int b = 0; b < nbytes; b++)
            ref_mem[it.addr + b] = it.wdata[8*((it.addr % NB) + b) +: 8];
      if (!e.err && !it.wr)
         for (int b = 0; b < NB; b++)
            e.data[8*b +: 8] = ref_mem[base + b];
      exp_q.push_back(e);
   endtask

   task automatic drive_idle();
      bus.hsel_i   = 1'b0;
      bus.htrans_i = 2'd0;
      bus.hwrite_i = 1'b0;
      bus.haddr_i  = '0;
      bus.hsize_i  = 3'd2;
      hold         = 1'b0;
   endtask

   task automatic run_items();
      int        ai     = 0;
      int        budget = 20000;
      bit        dp     = 0;
      bit        dpw    = 0;
      bit [31:0] dpd    = '0;
      bit        rdy;
      bit        use_it;
      item_t     it;
      while ((ai < items.size() || dp) && budget > 0) begin
         budget--;
         use_it = (ai < items.size());
         if (use_it && items[ai].hold && dp) use_it = 0;
         it = use_it ? items[ai] : mk(0, 0, 0, 0, 2, 0, 0);
         bus.hsel_i   = it.sel;
         bus.htrans_i = it.trans;
         bus.hwrite_i = it.wr;
         bus.haddr_i  = it.addr;
         bus.hsize_i  = it.size;
         hold         = it.hold;
         bus.hwdata_i = (dp && dpw) ? dpd : 32'h0;
         @(negedge hclk);
         rdy = bus.hready_i;
         @(posedge hclk);
         if (rdy) begin
            dp = 0;
            if (use_it) begin
               if (it.sel && it.trans[1]) begin
                  model_issue(it);
                  dp  = 1;
                  dpw = it.wr;
                  dpd = it.wdata;
               end
               ai++;
            end
         end else if (use_it && it.hold) begin
            ai++;
         end
         #1;
      end
      if (budget == 0) chk("drv_budget", 0, 1);
      drive_idle();
      items.delete();
   endtask

   // Monitor: follows the bus on its own and checks each data phase.
   bit dp_m  = 0;
   int stall = 0;
   always @(negedge hclk) begin
      exp_t e;
      if (!hresetn || !mon_en) begin
         dp_m  = 0;
         stall = 0;
      end else begin
         if (dp_m) begin
            if (exp_q.size() == 0) begin
               chk("sb_empty", 1, 0);
               dp_m = 0;
            end else if (!bus.hreadyout_o) begin
               stall++;
               chk("stall_resp", 32'(bus.hresp_o), 32'(exp_q[0].err));
            end else begin
               e = exp_q.pop_front();
               chk("resp", 32'(bus.hresp_o), 32'(e.err));
               chk("stalls", 32'(stall), e.err ? 32'd1 : 32'(WS));
               if (e.rd && !e.err) chk("rdata", bus.hrdata_o, e.data);
               dp_m  = 0;
               stall = 0;
            end
         end else begin
            chk("idle_rdy_resp", {30'd0, bus.hreadyout_o, bus.hresp_o}, 32'd2);
         end
         if (bus.hsel_i && bus.htrans_i[1] && bus.hready_i) dp_m = 1;
      end
   end

   initial begin
      bit [31:0] a;
      bit [2:0]  sz;
      drive_idle();
      bus.hwdata_i = '0;
      repeat (3) @(posedge hclk);
      @(negedge hclk);
      chk("rst_rdy", 32'(bus.hreadyout_o), 32'd1);
      chk("rst_resp", 32'(bus.hresp_o), 32'd0);
      chk("rst_rdata", bus.hrdata_o, 32'd0);
      hresetn = 1'b1;
      mon_en  = 1'b1;
      @(posedge hclk); #1;

      for (int w = 0; w < DEPTH; w++)
         items.push_back(mk(1, 2, 1, 32'(w*4), 2, $urandom, 0));
      run_items();

      items.push_back(mk(1, 2, 1, 32'h10, 2, 32'hDEADBEEF, 0));
      items.push_back(mk(1, 2, 0, 32'h10, 2, 0, 0));
      items.push_back(mk(1, 2, 1, 32'h20, 2, 32'h11223344, 0));
      items.push_back(mk(1, 2, 1, 32'h22, 0, 32'hAAAAAAAA, 0));
      items.push_back(mk(1, 2, 0, 32'h20, 2, 0, 0));
      items.push_back(mk(1, 2, 1, 32'h20, 1, 32'hBEEFBEEF, 0));
      items.push_back(mk(1, 2, 0, 32'h20, 2, 0, 0));
      items.push_back(mk(1, 2, 1, 32'h41, 0, 32'h55555555, 0));
      items.push_back(mk(1, 3, 0, 32'h40, 2, 0, 0));
      items.push_back(mk(1, 2, 0, 32'(DEPTH*4), 2, 0, 0));
      items.push_back(mk(1, 2, 1, 32'h03, 1, 32'h12345678, 0));
      items.push_back(mk(1, 2, 0, 32'h00, 2, 0, 0));
      for (int k = 0; k < 5; k++)
         items.push_back(mk(k[0], k[0] ? 2'd0 : 2'd2, 0, 32'h8, 2, 0, 0));
      items.push_back(mk(1, 1, 0, 32'h8, 2, 0, 0));
      for (int k = 0; k < 3; k++)
         items.push_back(mk(1, 2, 0, 32'h10, 2, 0, 1));
      items.push_back(mk(1, 2, 0, 32'h10, 2, 0, 0));
      run_items();

      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 9) == 0) begin
            items.push_back(mk($urandom_range(0, 1), 2'($urandom_range(0, 1)),
                               $urandom_range(0, 1), $urandom, 2, 0, 0));
         end else begin
            sz = 3'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0)
               a = 32'(DEPTH*4 + $urandom_range(0, 63));
            else
               a = 32'($urandom_range(0, DEPTH*4 - 1));
            if ($urandom_range(0, 7) != 0) a = a & ~((32'd1 << sz) - 1);
            items.push_back(mk(1, 2'($urandom_range(2, 3)),
                               $urandom_range(0, 1), a, sz, $urandom, 0));
         end
      end
      run_items();

      repeat (3) @(posedge hclk);
      #1;
      chk("drain", 32'(exp_q.size()), 32'd0);

      // Abort a write in its wait state; the array must keep the old word.
      mon_en       = 1'b0;
      bus.hsel_i   = 1'b1;
      bus.htrans_i = 2'd2;
      bus.hwrite_i = 1'b1;
      bus.haddr_i  = 32'h80;
      bus.hsize_i  = 3'd2;
      @(posedge hclk); #1;
      drive_idle();
      bus.hwdata_i = 32'hCAFEF00D;
      @(negedge hclk);
      chk("rst_wait_rdy", 32'(bus.hreadyout_o), 32'd0);
      #1;
      hresetn = 1'b0;
      #1;
      chk("rst_mid_rdy", 32'(bus.hreadyout_o), 32'd1);
      chk("rst_mid_resp", 32'(bus.hresp_o), 32'd0);
      chk("rst_mid_rdata", bus.hrdata_o, 32'd0);
      repeat (2) @(posedge hclk);
      @(negedge hclk);
      hresetn = 1'b1;
      mon_en  = 1'b1;
      @(posedge hclk); #1;
      items.push_back(mk(1, 2, 0, 32'h80, 2, 0, 0));
      items.push_back(mk(1, 2, 0, 32'h20, 2, 0, 0));
      run_items();
      repeat (3) @(posedge hclk);
      #1;
      chk("drain_end", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
